// File: rtl/dec_4_to_16_if.sv
// Decoder bus: enable/address/history-clear in, decode and history out.
// The master side drives the request; the slave side is the decoder.
interface dec_4_to_16_if;
    logic        EN;
    logic [3:0]  ADDR;
    logic        HIST_CLR;
    logic [15:0] DEC;
    logic        DEC_VALID;
    logic [15:0] HIST;

    modport master (
        output EN, ADDR, HIST_CLR,
        input  DEC, DEC_VALID, HIST
    );

    modport slave (
        input  EN, ADDR, HIST_CLR,
        output DEC, DEC_VALID, HIST
    );
endinterface

// File: rtl/dec_4_to_16.sv
// 4-to-16 one-hot decoder with selectable output polarity, optional
// output register, a decode-valid flag and a sticky address history.
module dec_4_to_16 #(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit REGISTERED = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    dec_4_to_16_if.slave  bus
);

    localparam logic [15:0] IDLE = ACTIVE_LOW ? 16'hFFFF : 16'h0000;

    logic [15:0] onehot;
    logic [15:0] dec_d;
    logic        valid_d, valid_q;
    logic [15:0] hist_d, hist_q;

    always_comb begin
        onehot = '0;
        if (bus.EN) begin
            onehot = 16'h0001 << bus.ADDR;
        end
    end

    // Polarity is applied once here; history always stays active-high.
    always_comb begin
        dec_d   = ACTIVE_LOW ? ~onehot : onehot;
        valid_d = bus.EN;
        hist_d  = hist_q;
        if (bus.HIST_CLR) begin
            hist_d = '0;
        end else if (bus.EN) begin
            hist_d = hist_q | onehot;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            hist_q  <= '0;
        end else begin
            valid_q <= valid_d;
            hist_q  <= hist_d;
        end
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [15:0] dec_q;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    dec_q <= IDLE;
                end else begin
                    dec_q <= dec_d;
                end
            end
            assign bus.DEC = dec_q;
        end else begin : g_comb
            assign bus.DEC = dec_d;
        end
    endgenerate

    assign bus.DEC_VALID = valid_q;
    assign bus.HIST      = hist_q;

endmodule

// File: tb/tb_dec_4_to_16.sv
// Directed and random checks of dec_4_to_16 in its default,
// active-low and combinational builds driven from shared stimulus.
module tb_dec_4_to_16;

    logic       CLK;
    logic       RST;
    logic       en;
    logic [3:0] addr;
    logic       hclr;

    int vectors;
    int miscompares;

    dec_4_to_16_if b_reg ();
    dec_4_to_16_if b_low ();
    dec_4_to_16_if b_cmb ();

    assign b_reg.EN = en;
    assign b_reg.ADDR = addr;
    assign b_reg.HIST_CLR = hclr;
    assign b_low.EN = en;
    assign b_low.ADDR = addr;
    assign b_low.HIST_CLR = hclr;
    assign b_cmb.EN = en;
    assign b_cmb.ADDR = addr;
    assign b_cmb.HIST_CLR = hclr;

    dec_4_to_16 u_reg (
        .CLK (CLK),
        .RST (RST),
        .bus (b_reg.slave)
    );

    dec_4_to_16 #(.ACTIVE_LOW(1'b1)) u_low (
        .CLK (CLK),
        .RST (RST),
        .bus (b_low.slave)
    );

    dec_4_to_16 #(.REGISTERED(1'b0)) u_cmb (
        .CLK (CLK),
        .RST (RST),
        .bus (b_cmb.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] hist_m;
        logic [15:0] dec_m;
        logic        val_m;
        vectors = 0;
        miscompares = 0;
        RST = 1'b1;
        en = 1'b0;
        addr = 4'd0;
        hclr = 1'b0;

        // Reset state
        tick();
        chk("rst_dec", b_reg.DEC, 16'h0000);
        chk("rst_valid", {15'd0, b_reg.DEC_VALID}, 16'h0000);
        chk("rst_hist", b_reg.HIST, 16'h0000);
        chk("rst_dec_low", b_low.DEC, 16'hFFFF);
        chk("rst_dec_cmb", b_cmb.DEC, 16'h0000);

        // Sweep every address
        RST = 1'b0;
        for (int a = 0; a < 16; a++) begin
            en = 1'b1;
            addr = 4'(a);
            #1;
            chk("sweep_cmb", b_cmb.DEC, 16'h0001 << a);
            tick();
            chk("sweep_dec", b_reg.DEC, 16'h0001 << a);
            chk("sweep_valid", {15'd0, b_reg.DEC_VALID}, 16'h0001);
        end
        chk("sweep_hist", b_reg.HIST, 16'hFFFF);

        // Enable gating
        en = 1'b0;
        addr = 4'd5;
        tick();
        chk("gate_dec", b_reg.DEC, 16'h0000);
        chk("gate_valid", {15'd0, b_reg.DEC_VALID}, 16'h0000);
        chk("gate_hist", b_reg.HIST, 16'hFFFF);
        chk("gate_dec_low", b_low.DEC, 16'hFFFF);
        chk("gate_dec_cmb", b_cmb.DEC, 16'h0000);
        en = 1'b1;
        tick();
        chk("gate_en_dec", b_reg.DEC, 16'h0020);
        chk("gate_en_low", b_low.DEC, 16'hFFDF);

        // History clear
        en = 1'b0;
        hclr = 1'b1;
        tick();
        chk("clr_hist0", b_reg.HIST, 16'h0000);
        hclr = 1'b0;
        en = 1'b1;
        addr = 4'd3;
        tick();
        addr = 4'd9;
        tick();
        chk("clr_hist39", b_reg.HIST, 16'h0208);
        hclr = 1'b1;
        addr = 4'd1;
        tick();
        chk("clr_prio_hist", b_reg.HIST, 16'h0000);
        chk("clr_prio_dec", b_reg.DEC, 16'h0002);
        chk("clr_prio_valid", {15'd0, b_reg.DEC_VALID}, 16'h0001);
        hclr = 1'b0;

        // Reset mid-run
        addr = 4'd7;
        RST = 1'b1;
        tick();
        chk("mrst_dec", b_reg.DEC, 16'h0000);
        chk("mrst_valid", {15'd0, b_reg.DEC_VALID}, 16'h0000);
        chk("mrst_hist", b_reg.HIST, 16'h0000);
        chk("mrst_low", b_low.DEC, 16'hFFFF);
        chk("mrst_cmb", b_cmb.DEC, 16'h0080);
        RST = 1'b0;
        tick();
        chk("mrst_resume", b_reg.DEC, 16'h0080);
        chk("mrst_resume_hist", b_reg.HIST, 16'h0080);

        // Active-low build
        addr = 4'hA;
        tick();
        chk("low_dec_a", b_low.DEC, 16'hFBFF);
        chk("low_hist", b_low.HIST, 16'h0480);
        en = 1'b0;
        tick();
        chk("low_dec_off", b_low.DEC, 16'hFFFF);

        // Random traffic against a reference model
        hist_m = b_reg.HIST;
        chk("rnd_hist_start", hist_m, 16'h0480);
        for (int i = 0; i < 1000; i++) begin
            en = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            hclr = ($urandom_range(0, 15) == 0);
            dec_m = en ? (16'h0001 << addr) : 16'h0000;
            val_m = en;
            if (hclr) begin
                hist_m = 16'h0000;
            end else begin
                hist_m = hist_m | dec_m;
            end
            #1;
            chk("rnd_cmb_dec", b_cmb.DEC, dec_m);
            tick();
            chk("rnd_dec", b_reg.DEC, dec_m);
            chk("rnd_valid", {15'd0, b_reg.DEC_VALID}, {15'd0, val_m});
            chk("rnd_ones", 16'($countones(b_reg.DEC)),
                b_reg.DEC_VALID ? 16'd1 : 16'd0);
            chk("rnd_hist", b_reg.HIST, hist_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dec_4_to_16.md
DEC_4_TO_16 -- requirements
Module: dec_4_to_16

Interface
REQ-001 Parameter ACTIVE_LOW, default 0: output polarity; 0 = asserted bit is 1, 1 = asserted bit is 0 and idle bits are 1.
REQ-002 Parameter REGISTERED, default 1: 1 = registered decode with 1-cycle latency; 0 = combinational DEC path, while DEC_VALID and HIST stay registered.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 EN  input  1  decode enable.
REQ-006 ADDR  input  4  address to decode, unsigned 0..15.
REQ-007 DEC  output  16  one-hot decoded output; bit ADDR is asserted.
REQ-008 DEC_VALID  output  1  high when DEC holds a decode of an enabled ADDR.
REQ-009 HIST_CLR  input  1  synchronous clear of the history register.
REQ-010 HIST  output  16  sticky record of every address decoded since the last reset or clear.

Function
REQ-011 With EN=1, DEC shall have exactly bit ADDR asserted and all other 15 bits idle (ADDR=0 -> bit 0, ADDR=15 -> bit 15).
REQ-012 With EN=0, all 16 DEC bits shall be idle (0x0000, or 0xFFFF when ACTIVE_LOW=1).
REQ-013 With REGISTERED=1, DEC shall reflect the ADDR/EN sampled at rising edge N starting just after edge N, giving 1-cycle latency.
REQ-014 With REGISTERED=0, DEC shall follow ADDR/EN combinationally, and RST shall not affect DEC.
REQ-015 DEC_VALID shall be a register loaded with EN each cycle, so it is high one cycle after an enabled sample.
REQ-016 At most one DEC bit shall be asserted in any cycle, including back-to-back address changes every cycle.
REQ-017 HIST shall update each cycle as HIST <= HIST | onehot(ADDR) when EN=1 and shall hold when EN=0; HIST is always active-high regardless of ACTIVE_LOW.
REQ-018 HIST_CLR=1 shall load HIST with 0 and take priority over a simultaneous enabled decode, so that decode is not recorded.
REQ-019 HIST_CLR shall not affect DEC or DEC_VALID.
REQ-020 ADDR values sampled while EN=0 shall have no effect on any output.
REQ-021 The design shall contain no latches, and all outputs shall be driven in every state.

Reset
REQ-022 RST=1 at a rising edge shall set registered DEC to idle (0x0000, or 0xFFFF when ACTIVE_LOW=1), DEC_VALID to 0 and HIST to 0x0000.
REQ-023 RST shall have priority over EN, ADDR and HIST_CLR.
REQ-024 If RST is asserted mid-sequence, outputs shall be idle on the next cycle, and decoding shall resume on the first edge with RST=0 and EN=1.
REQ-025 Output values before the first reset are unspecified, and the bench shall not check them.

Verification
REQ-026 Sweep: RST pulse, then EN=1 and ADDR=0..15, one value per cycle -> one cycle later DEC=0x0001, 0x0002, ... 0x8000, DEC_VALID=1, and final HIST=0xFFFF.
REQ-027 Enable gating: EN=0 with ADDR=5 -> next cycle DEC=0x0000, DEC_VALID=0 and HIST unchanged; then EN=1 -> next cycle DEC=0x0020.
REQ-028 History clear: after ADDR 3 and 9 are decoded, HIST=0x0208; HIST_CLR=1 with EN=1 and ADDR=1 -> HIST=0x0000 while DEC=0x0002.
REQ-029 Reset mid-run: EN=1, ADDR=7, RST=1 for one cycle -> DEC=0x0000, DEC_VALID=0, HIST=0x0000; next cycle DEC=0x0080.
REQ-030 ACTIVE_LOW=1 build: ADDR=0xA, EN=1 -> DEC=0xFBFF; EN=0 -> DEC=0xFFFF.
REQ-031 One-hot checker: random ADDR and EN for 1000 cycles -> the count of asserted DEC bits is 1 exactly when DEC_VALID=1, and 0 otherwise.
